// File: rtl/regfl_pkg.sv
// Shared types and helpers for the multi-port register file.
//   clr_state_e : clear sequencer states
//   merge_be    : byte-lane merge used by both the write path and the read bypass
//                 (operates at MAX_W; callers zero-extend and slice back to W)
package regfl_pkg;

   typedef enum logic {IDLE = 1'b0, CLR = 1'b1} clr_state_e;

   localparam int MAX_W  = 1024;
   localparam int MAX_BL = MAX_W / 8;

   function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0]  old_v,
                                                 input logic [MAX_W-1:0]  new_v,
                                                 input logic [MAX_BL-1:0] be);
      logic [MAX_W-1:0] r;
      for (int b = 0; b < MAX_BL; b++)
         r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/regfl_mp_if.sv
// Bus interface for regfl_mp.
//   master : drives write port, read addresses and clear request
//   slave  : the register file; returns read data, clear status and flat contents
interface regfl_mp_if #(
   parameter int W = 64,
   parameter int N = 8
);
   localparam int AW = $clog2(N);
   localparam int BL = W / 8;

   logic          we;
   logic [AW-1:0] wa;
   logic [W-1:0]  wd;
   logic [BL-1:0] wbe;
   logic [AW-1:0] ra0;
   logic [AW-1:0] ra1;
   logic [W-1:0]  rd0;
   logic [W-1:0]  rd1;
   logic          clr_req;
   logic          busy;
   logic          clr_done;
   logic [N*W-1:0] q;

   modport master (output we, wa, wd, wbe, ra0, ra1, clr_req,
                   input  rd0, rd1, busy, clr_done, q);
   modport slave  (input  we, wa, wd, wbe, ra0, ra1, clr_req,
                   output rd0, rd1, busy, clr_done, q);
endinterface

// File: rtl/regfl_clr_seq.sv
// Background clear sequencer: on clr_req (in IDLE) walks cnt 0..N-1, one entry per edge.
//   clk, rst  : clock / async active-high reset
//   clr_req   : start request, ignored while a clear runs
//   clr_en    : current edge zeroes entry clr_idx
//   clr_idx   : entry being cleared
//   busy      : clear in progress
//   clr_done  : one-cycle pulse after the last entry is cleared
module regfl_clr_seq
   import regfl_pkg::*;
#(
   parameter int N = 8,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx,
   output logic          busy,
   output logic          clr_done
);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CLR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(N - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign clr_en   = (state_q == CLR);
   assign clr_idx  = cnt_q;
   assign busy     = busy_q;
   assign clr_done = done_q;

endmodule

// File: rtl/regfl_mp.sv
// Multi-port register file: N x W entries, one byte-masked write port, two registered
// read ports with write-to-read bypass, flat contents view and a background clear.
//   clk, rst : clock / async active-high reset
//   bus      : regfl_mp_if slave (we/wa/wd/wbe, ra0/ra1 -> rd0/rd1, clr_req -> busy/clr_done, q)
module regfl_mp
   import regfl_pkg::*;
#(
   parameter int W = 64,
   parameter int N = 8
) (
   input  logic       clk,
   input  logic       rst,
   regfl_mp_if.slave  bus
);

   localparam int AW = $clog2(N);
   localparam int BL = W / 8;
   // one extra bit so out-of-range addresses compare correctly when N is a power of two
   localparam logic [AW:0] N_L = (AW+1)'(N);

   function automatic logic [W-1:0] merge_w(input logic [W-1:0]  old_v,
                                            input logic [W-1:0]  new_v,
                                            input logic [BL-1:0] be);
      logic [MAX_W-1:0] t;
      t = merge_be(MAX_W'(old_v), MAX_W'(new_v), MAX_BL'(be));
      return t[W-1:0];
   endfunction

   logic [N-1:0][W-1:0] mem_q;
   logic [W-1:0]        rd0_q, rd0_d, rd1_q, rd1_d;
   logic                clr_en, busy, clr_done;
   logic [AW-1:0]       clr_idx;
   logic                wa_ok, ra0_ok, ra1_ok, wr_ok;
   logic [W-1:0]        wr_merged;

   regfl_clr_seq #(.N(N)) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (bus.clr_req),
      .clr_en   (clr_en),
      .clr_idx  (clr_idx),
      .busy     (busy),
      .clr_done (clr_done)
   );

   // writes are dropped while the clear runs
   always_comb begin
      wa_ok     = ({1'b0, bus.wa}  < N_L);
      ra0_ok    = ({1'b0, bus.ra0} < N_L);
      ra1_ok    = ({1'b0, bus.ra1} < N_L);
      wr_ok     = bus.we && !busy && wa_ok;
      wr_merged = merge_w(wa_ok ? mem_q[bus.wa] : '0, bus.wd, bus.wbe);
   end

   for (genvar i = 0; i < N; i++) begin : g_ent
      logic [W-1:0] ent_q, ent_d;
      logic         wr_stb, clr_stb;

      always_comb begin
         wr_stb  = wr_ok && (bus.wa == AW'(i));
         clr_stb = clr_en && (clr_idx == AW'(i));
         ent_d   = ent_q;
         if (clr_stb)     ent_d = '0;
         else if (wr_stb) ent_d = wr_merged;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) ent_q <= '0;
         else     ent_q <= ent_d;
      end

      assign mem_q[i] = ent_q;
   end

   // bypass only sees committed writes, so a cleared entry is never bypassed
   always_comb begin
      rd0_d = '0;
      rd1_d = '0;
      if (ra0_ok) rd0_d = (wr_ok && bus.wa == bus.ra0) ? wr_merged : mem_q[bus.ra0];
      if (ra1_ok) rd1_d = (wr_ok && bus.wa == bus.ra1) ? wr_merged : mem_q[bus.ra1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd0_q <= '0;
         rd1_q <= '0;
      end else begin
         rd0_q <= rd0_d;
         rd1_q <= rd1_d;
      end
   end

   assign bus.rd0      = rd0_q;
   assign bus.rd1      = rd1_q;
   assign bus.busy     = busy;
   assign bus.clr_done = clr_done;
   assign bus.q        = mem_q;

endmodule
